// File: rtl/disp_axil_regs.sv
// disp_axil_regs: AXI4-Lite register slave for the 7-segment display IP.
//
// Holds four 32-bit registers (DATA, CTRL, SCAN_DIV, SCRATCH) and drives a
// time-multiplexed, common-anode 7-segment display from them.
//
// Ports:
//   ACLK, ARESET        clock (rising edge) and synchronous active-high reset
//   S_AXI_AW*/W*/B*     AXI4-Lite write channel, one outstanding write
//   S_AXI_AR*/R*        AXI4-Lite read channel, one outstanding read
//   disp_an             digit enables, active low
//   disp_seg            segments {g..a}, active low
//   disp_dp             decimal point, active low (only with DISP_DP_EN)
//
// Build option: define DISP_DP_EN to add disp_dp, driven from CTRL[15:8].
// Without it, CTRL[15:8] are plain read/write storage.
//
// Register map (byte offset): 0x0 DATA, 0x4 CTRL, 0x8 SCAN_DIV, 0xC SCRATCH.
module disp_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_DIGITS         = 8,
  parameter int SCAN_DIV_RST       = 50000
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_DIGITS-1:0]             disp_an,
  output logic [6:0]                        disp_seg
`ifdef DISP_DP_EN
  ,
  output logic                              disp_dp
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [31:0] reg_data, reg_ctrl, reg_div, reg_scr;

  logic        wr_en, rd_en;
  logic [31:0] rd_mux;

  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic [15:0] div_eff;
  logic        scan_tc;
  logic        digit_on;
  logic [3:0]  nibble;
  logic [7:0]  blank_mask;
  logic [NUM_DIGITS-1:0] an_onehot;

  // AXI protection bits and byte-offset bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------- write channel ----------------
  // The real handshake is the cycle where both READYs are high and the
  // master still holds both VALIDs; the registers update on that edge.
  assign wr_en       = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WREADY && S_AXI_WVALID;
  assign S_AXI_BRESP = 2'b00;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID;
      S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID;
      if (wr_en)                             S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      reg_data <= '0;
      reg_ctrl <= '0;
      reg_div  <= 32'(SCAN_DIV_RST);
      reg_scr  <= '0;
    end else if (wr_en) begin
      case (S_AXI_AWADDR[3:2])
        2'd0:    reg_data <= apply_strb(reg_data, S_AXI_WDATA, S_AXI_WSTRB);
        2'd1:    reg_ctrl <= apply_strb(reg_ctrl, S_AXI_WDATA, S_AXI_WSTRB);
        2'd2:    reg_div  <= apply_strb(reg_div,  S_AXI_WDATA, S_AXI_WSTRB);
        default: reg_scr  <= apply_strb(reg_scr,  S_AXI_WDATA, S_AXI_WSTRB);
      endcase
    end
  end

  // ---------------- read channel ----------------
  // RDATA is sampled from the register values before any same-edge write.
  assign rd_en       = S_AXI_ARREADY && S_AXI_ARVALID;
  assign S_AXI_RRESP = 2'b00;

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux = reg_data;
      2'd1:    rd_mux = reg_ctrl;
      2'd2:    rd_mux = reg_div;
      default: rd_mux = reg_scr;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
      if (rd_en) begin
        S_AXI_RDATA  <= rd_mux;
        S_AXI_RVALID <= 1'b1;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // ---------------- scan engine ----------------
  // Using >= for terminal count lets a smaller SCAN_DIV take effect at once
  // when the prescaler is already past the new limit.
  assign div_eff = (reg_div[15:0] == 16'd0) ? 16'd1 : reg_div[15:0];
  assign scan_tc = (scan_cnt >= (div_eff - 16'd1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (reg_ctrl[0]) begin
      if (scan_tc) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == LAST_IDX) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  assign blank_mask = reg_ctrl[23:16];
  assign digit_on   = reg_ctrl[0] && !blank_mask[digit_idx];
  assign nibble     = reg_data[{digit_idx, 2'b00} +: 4];
  assign an_onehot  = NUM_DIGITS'(1) << digit_idx;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      disp_an  <= '1;
      disp_seg <= 7'h7F;
    end else begin
      disp_an  <= digit_on ? ~an_onehot : '1;
      disp_seg <= digit_on ? hex_to_seg(nibble) : 7'h7F;
    end
  end

`ifdef DISP_DP_EN
  logic [7:0] dp_mask;
  assign dp_mask = reg_ctrl[15:8];

  always_ff @(posedge ACLK) begin
    if (ARESET) disp_dp <= 1'b1;
    else        disp_dp <= digit_on ? ~dp_mask[digit_idx] : 1'b1;
  end
`endif

endmodule

// File: tb/tb_disp_axil_regs.sv
module tb_disp_axil_regs;
  logic        ACLK, ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [7:0]  disp_an;
  logic [6:0]  disp_seg;
`ifdef DISP_DP_EN
  logic        disp_dp;
`endif

  int n_pass = 0;
  int n_total = 0;

  disp_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_DIGITS(8), .SCAN_DIV_RST(50000)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .disp_an(disp_an), .disp_seg(disp_seg)
`ifdef DISP_DP_EN
    , .disp_dp(disp_dp)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int t;
    t = 0;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    do begin tick(); t++; end while (!S_AXI_AWREADY && t < 50);
    if (!S_AXI_AWREADY) begin
      n_total++;
      $display("FAIL wr_timeout addr=%h awready=%b required=1", addr, S_AXI_AWREADY);
    end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    resp = S_AXI_BVALID ? S_AXI_BRESP : 2'bxx;
    tick();
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    t = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    do begin tick(); t++; end while (!S_AXI_ARREADY && t < 50);
    if (!S_AXI_ARREADY) begin
      n_total++;
      $display("FAIL rd_timeout addr=%h arready=%b required=1", addr, S_AXI_ARREADY);
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    if (S_AXI_RVALID) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
    else begin data = 'x; resp = 'x; end
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    ARESET = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;
    n_total++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
      $display("FAIL reset_handshake got=%b required=00000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
    end else n_pass++;
    n_total++;
    if ({S_AXI_BRESP, S_AXI_RRESP} !== 4'b0) begin
      $display("FAIL reset_resp got=%b required=0000", {S_AXI_BRESP, S_AXI_RRESP});
    end else n_pass++;
    n_total++;
    if (S_AXI_RDATA !== 32'h0) $display("FAIL reset_rdata got=%h required=0", S_AXI_RDATA);
    else n_pass++;
    n_total++;
    if (disp_an !== 8'hFF) $display("FAIL reset_an got=%h required=ff", disp_an);
    else n_pass++;
    n_total++;
    if (disp_seg !== 7'h7F) $display("FAIL reset_seg got=%h required=7f", disp_seg);
    else n_pass++;
    axi_read(4'h8, d, r);
    n_total++;
    if (d !== 32'd50000 || r !== 2'b00) $display("FAIL reset_scan_div got=%h/%b required=0000c350/00", d, r);
    else n_pass++;
    axi_read(4'h0, d, r);
    n_total++;
    if (d !== 32'h0 || r !== 2'b00) $display("FAIL reset_data got=%h/%b required=0/00", d, r);
    else n_pass++;
  endtask

  task automatic test_basic_rw();
    logic [31:0] d; logic [1:0] r;
    logic [3:0]  addrs [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    for (int i = 0; i < 4; i++) begin
      axi_write(addrs[i], 32'(i + 1), 4'hF, r);
      n_total++;
      if (r !== 2'b00) $display("FAIL basic_bresp addr=%h got=%b required=00", addrs[i], r);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], d, r);
      n_total++;
      if (d !== 32'(i + 1) || r !== 2'b00)
        $display("FAIL basic_read addr=%h got=%h/%b required=%h/00", addrs[i], d, r, 32'(i + 1));
      else n_pass++;
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r;
    axi_write(4'h0, 32'h12345678, 4'hF, r);
    axi_write(4'h0, 32'hAABBCCDD, 4'b0010, r);
    axi_read(4'h0, d, r);
    n_total++;
    if (d !== 32'h1234CC78) $display("FAIL strobe_merge got=%h required=1234cc78", d);
    else n_pass++;
  endtask

  task automatic test_aw_wait();
    logic [31:0] d; logic [1:0] r;
    int t;
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h5A5A0001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00)
        $display("FAIL aw_only_ready cycle=%0d got=%b required=00", i, {S_AXI_AWREADY, S_AXI_WREADY});
      else n_pass++;
    end
    S_AXI_WVALID = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!S_AXI_AWREADY && t < 50);
    n_total++;
    if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11)
      $display("FAIL aw_w_joint got=%b required=11", {S_AXI_AWREADY, S_AXI_WREADY});
    else n_pass++;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n_total++;
    if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00)
      $display("FAIL aw_w_single_pulse got=%b required=00", {S_AXI_AWREADY, S_AXI_WREADY});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00)
        $display("FAIL bvalid_hold cycle=%0d got=%b/%b required=1/00", i, S_AXI_BVALID, S_AXI_BRESP);
      else n_pass++;
      tick();
    end
    S_AXI_BREADY = 1'b1;
    tick();
    n_total++;
    if (S_AXI_BVALID !== 1'b0) $display("FAIL bvalid_clear got=%b required=0", S_AXI_BVALID);
    else n_pass++;
    axi_read(4'hC, d, r);
    n_total++;
    if (d !== 32'h5A5A0001) $display("FAIL aw_wait_data got=%h required=5a5a0001", d);
    else n_pass++;
  endtask

  task automatic test_scan();
    logic [1:0] r;
    logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    int t;
    axi_write(4'h0, 32'h76543210, 4'hF, r);
    axi_write(4'h8, 32'd4, 4'hF, r);
    axi_write(4'h4, 32'h1, 4'hF, r);
    t = 0;
    while (disp_an === 8'hFF && t < 50) begin tick(); t++; end
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        n_total++;
        if (disp_an !== an_tab[k % 8] || disp_seg !== seg_tab[k % 8])
          $display("FAIL scan digit=%0d cycle=%0d got=%h/%h required=%h/%h",
                   k, c, disp_an, disp_seg, an_tab[k % 8], seg_tab[k % 8]);
        else n_pass++;
        tick();
      end
    end
  endtask

  task automatic test_blank_disable();
    logic [1:0] r;
    int t;
    axi_write(4'h4, 32'h00020001, 4'hF, r);
    t = 0;
    while (disp_an !== 8'hFE && t < 64) begin tick(); t++; end
    t = 0;
    while (disp_an === 8'hFE && t < 10) begin tick(); t++; end
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if (disp_an !== 8'hFF || disp_seg !== 7'h7F)
        $display("FAIL blank_digit1 cycle=%0d got=%h/%h required=ff/7f", c, disp_an, disp_seg);
      else n_pass++;
      tick();
    end
    n_total++;
    if (disp_an !== 8'hFB || disp_seg !== 7'h24)
      $display("FAIL after_blank got=%h/%h required=fb/24", disp_an, disp_seg);
    else n_pass++;
    // Disable while digit 2 is showing; the index must freeze at 2.
    axi_write(4'h4, 32'h0, 4'hF, r);
    for (int c = 0; c < 8; c++) begin
      n_total++;
      if (disp_an !== 8'hFF || disp_seg !== 7'h7F)
        $display("FAIL disabled cycle=%0d got=%h/%h required=ff/7f", c, disp_an, disp_seg);
      else n_pass++;
      tick();
    end
    axi_write(4'h4, 32'h1, 4'hF, r);
    t = 0;
    while (disp_an === 8'hFF && t < 50) begin tick(); t++; end
    n_total++;
    if (disp_an !== 8'hFB || disp_seg !== 7'h24)
      $display("FAIL resume_held_index got=%h/%h required=fb/24", disp_an, disp_seg);
    else n_pass++;
    t = 0;
    while (disp_an === 8'hFB && t < 10) begin tick(); t++; end
    n_total++;
    if (disp_an !== 8'hF7 || disp_seg !== 7'h30)
      $display("FAIL resume_next got=%h/%h required=f7/30", disp_an, disp_seg);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] d; logic [1:0] r;
    int t;
    axi_write(4'hC, 32'h11, 4'hF, r);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h22; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!S_AXI_AWREADY && t < 50);
    n_total++;
    if ({S_AXI_AWREADY, S_AXI_ARREADY} !== 2'b11)
      $display("FAIL simul_ready got=%b required=11", {S_AXI_AWREADY, S_AXI_ARREADY});
    else n_pass++;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    n_total++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_BVALID !== 1'b1 || S_AXI_RDATA !== 32'h11)
      $display("FAIL simul_prewrite got=%b/%b/%h required=1/1/00000011",
               S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA);
    else n_pass++;
    tick();
    axi_read(4'hC, d, r);
    n_total++;
    if (d !== 32'h22) $display("FAIL simul_postwrite got=%h required=00000022", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    int t;
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h7; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    t = 0;
    do begin tick(); t++; end while (!S_AXI_AWREADY && t < 50);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    t = 0;
    do begin tick(); t++; end while (!S_AXI_ARREADY && t < 50);
    tick();
    S_AXI_ARVALID = 1'b0;
    n_total++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA} !== {2'b11, 32'h7})
      $display("FAIL pending_before_reset got=%b%b/%h required=11/00000007",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
    else n_pass++;
    ARESET = 1'b1;
    tick();
    n_total++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00)
      $display("FAIL reset_abort got=%b required=00", {S_AXI_BVALID, S_AXI_RVALID});
    else n_pass++;
    n_total++;
    if (disp_an !== 8'hFF) $display("FAIL reset_mid_an got=%h required=ff", disp_an);
    else n_pass++;
    ARESET = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    axi_read(4'h8, d, r);
    n_total++;
    if (d !== 32'd50000) $display("FAIL reset_mid_scan_div got=%h required=0000c350", d);
    else n_pass++;
    axi_read(4'h4, d, r);
    n_total++;
    if (d !== 32'h0) $display("FAIL reset_mid_ctrl got=%h required=0", d);
    else n_pass++;
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    test_reset();
    test_basic_rw();
    test_strobe();
    test_aw_wait();
    test_scan();
    test_blank_disable();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
